// File: rtl/mem_arbiter_if.sv
// Bundle of IF-stage, MEM-stage and RAM-side signals around the shared-RAM arbiter.
// Handshake: a requester holds *_req_i (and its address/data) until the matching
// *_ready_o pulse; the RAM holds ram_ack_i for one edge while ram_req_o is high.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int SEL_W = DATA_W / 8;

    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic [DATA_W-1:0] if_rdata_o;
    logic              if_ready_o;

    logic              mem_req_i;
    logic              mem_we_i;
    logic [SEL_W-1:0]  mem_sel_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [DATA_W-1:0] mem_wdata_i;
    logic [DATA_W-1:0] mem_rdata_o;
    logic              mem_ready_o;

    logic              err_o;

    logic              ram_req_o;
    logic              ram_we_o;
    logic [SEL_W-1:0]  ram_sel_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [DATA_W-1:0] ram_wdata_o;
    logic [DATA_W-1:0] ram_rdata_i;
    logic              ram_ack_i;

    logic              stall_o;

    // Arbiter side
    modport slave (
        input  if_req_i, if_addr_i,
        output if_rdata_o, if_ready_o,
        input  mem_req_i, mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i,
        output mem_rdata_o, mem_ready_o,
        output err_o,
        output ram_req_o, ram_we_o, ram_sel_o, ram_addr_o, ram_wdata_o,
        input  ram_rdata_i, ram_ack_i,
        output stall_o
    );

    // Pipeline stages plus RAM side
    modport master (
        output if_req_i, if_addr_i,
        input  if_rdata_o, if_ready_o,
        output mem_req_i, mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i,
        input  mem_rdata_o, mem_ready_o,
        input  err_o,
        input  ram_req_o, ram_we_o, ram_sel_o, ram_addr_o, ram_wdata_o,
        output ram_rdata_i, ram_ack_i,
        input  stall_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// Fixed-priority (MEM over IF) arbiter for the single-port RAM, with a bounded
// wait on ram_ack_i and a one-cycle ready pulse per served access.
module mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int WAIT_MAX = 255
) (
    input  logic        clk,
    input  logic        rst,
    mem_arbiter_if.slave bus,
    output logic [1:0]  state_o
);
    localparam int SEL_W = DATA_W / 8;
    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DATA_BUSY = 2'd1,
        INST_BUSY = 2'd2,
        DONE      = 2'd3
    } state_e;

    state_e            state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              ram_req_q,   ram_req_d;
    logic              ram_we_q,    ram_we_d;
    logic [SEL_W-1:0]  ram_sel_q,   ram_sel_d;
    logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              if_ready_q,  if_ready_d;
    logic              mem_ready_q, mem_ready_d;
    logic              err_q,       err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_sel_q   <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ram_req_q   <= ram_req_d;
            ram_we_q    <= ram_we_d;
            ram_sel_q   <= ram_sel_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_ready_q  <= if_ready_d;
            mem_ready_q <= mem_ready_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ram_req_d   = ram_req_q;
        ram_we_d    = ram_we_q;
        ram_sel_d   = ram_sel_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_ready_d  = 1'b0;
        mem_ready_d = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.mem_req_i) begin
                    ram_req_d   = 1'b1;
                    ram_we_d    = bus.mem_we_i;
                    ram_sel_d   = bus.mem_sel_i;
                    ram_addr_d  = bus.mem_addr_i;
                    ram_wdata_d = bus.mem_wdata_i;
                    cnt_d       = '0;
                    state_d     = DATA_BUSY;
                end else if (bus.if_req_i) begin
                    ram_req_d   = 1'b1;
                    ram_we_d    = 1'b0;
                    ram_sel_d   = '1;
                    ram_addr_d  = bus.if_addr_i;
                    cnt_d       = '0;
                    state_d     = INST_BUSY;
                end
            end

            DATA_BUSY, INST_BUSY: begin
                // An ack on the same edge the budget runs out still counts as success.
                if (bus.ram_ack_i) begin
                    ram_req_d = 1'b0;
                    state_d   = DONE;
                    if (state_q == DATA_BUSY) begin
                        mem_rdata_d = ram_we_q ? '0 : bus.ram_rdata_i;
                        mem_ready_d = 1'b1;
                    end else begin
                        if_rdata_d  = bus.ram_rdata_i;
                        if_ready_d  = 1'b1;
                    end
                end else if (cnt_q == CNT_W'(WAIT_MAX - 1)) begin
                    ram_req_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = DONE;
                    if (state_q == DATA_BUSY) begin
                        mem_rdata_d = '0;
                        mem_ready_d = 1'b1;
                    end else begin
                        if_rdata_d  = '0;
                        if_ready_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DONE: begin
                // The served requester drops its request during the ready cycle,
                // so no grant is made here.
                state_d = IDLE;
            end

            default: begin
                state_d   = IDLE;
                ram_req_d = 1'b0;
            end
        endcase
    end

    assign bus.ram_req_o   = ram_req_q;
    assign bus.ram_we_o    = ram_we_q;
    assign bus.ram_sel_o   = ram_sel_q;
    assign bus.ram_addr_o  = ram_addr_q;
    assign bus.ram_wdata_o = ram_wdata_q;
    assign bus.if_rdata_o  = if_rdata_q;
    assign bus.if_ready_o  = if_ready_q;
    assign bus.mem_rdata_o = mem_rdata_q;
    assign bus.mem_ready_o = mem_ready_q;
    assign bus.err_o       = err_q;

    assign bus.stall_o = (bus.mem_req_i & ~mem_ready_q) | (bus.if_req_i & ~if_ready_q);

    assign state_o = state_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter: a RAM responder with programmable
// ack delay, and a transaction-level model of grant order, data and timing.
module tb_mem_arbiter;
    localparam int WAIT_MAX = 8;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic        we;
        int          cyc;
        bit          unstable;
    } grant_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] state_dbg;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_MAX(WAIT_MAX)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (state_dbg)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- RAM contents (responder) and reference memory (model)
    logic [31:0] ram_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    function automatic logic [31:0] fill_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] sel,
                                          input logic [31:0] wd);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (sel[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : fill_word(a);
    endfunction

    function automatic logic [31:0] ram_read(input logic [31:0] a);
        return ram_mem.exists(a) ? ram_mem[a] : fill_word(a);
    endfunction

    // ---------------- RAM responder
    int     ack_delay = 1;
    bit     stray_ack = 1'b0;
    int     r_cnt     = 0;
    grant_t cur;
    grant_t grant_q[$];

    initial begin
        bus.ram_ack_i   = 1'b0;
        bus.ram_rdata_i = '0;
    end

    always @(posedge clk) begin
        #1;
        if (bus.ram_req_o) begin
            if (r_cnt == 0) begin
                cur.addr     = bus.ram_addr_o;
                cur.wdata    = bus.ram_wdata_o;
                cur.sel      = bus.ram_sel_o;
                cur.we       = bus.ram_we_o;
                cur.unstable = 1'b0;
            end else if (cur.addr !== bus.ram_addr_o || cur.wdata !== bus.ram_wdata_o ||
                         cur.sel !== bus.ram_sel_o || cur.we !== bus.ram_we_o) begin
                cur.unstable = 1'b1;
            end
            r_cnt++;
            cur.cyc = r_cnt;
            if (r_cnt == ack_delay) begin
                bus.ram_ack_i   = 1'b1;
                bus.ram_rdata_i = ram_read(cur.addr);
                if (cur.we) ram_mem[cur.addr] = merge(ram_read(cur.addr), cur.sel, cur.wdata);
            end else begin
                bus.ram_ack_i   = 1'b0;
                bus.ram_rdata_i = $urandom();
            end
        end else begin
            if (r_cnt != 0) begin
                grant_q.push_back(cur);
                r_cnt = 0;
            end
            bus.ram_ack_i   = stray_ack;
            bus.ram_rdata_i = $urandom();
        end
    end

    // ---------------- transaction model and driver
    logic [31:0] m_if_rdata  = '0;
    logic [31:0] m_mem_rdata = '0;

    task automatic run_pair(input bit do_mem, input bit do_if, input bit we,
                            input logic [3:0] sel, input logic [31:0] maddr,
                            input logic [31:0] wdata, input logic [31:0] iaddr,
                            input int delay);
        grant_t      exp_q[$];
        grant_t      g;
        grant_t      got;
        int          cyc, n, mem_lat, if_lat;
        bit          exp_err, mem_pend, if_pend, got_merr, got_ierr;
        logic [31:0] got_mrd, got_ird;

        cyc     = (delay > WAIT_MAX) ? WAIT_MAX : delay;
        exp_err = (delay > WAIT_MAX);
        mem_lat = 0; if_lat = 0; got_merr = 0; got_ierr = 0; got_mrd = '0; got_ird = '0;
        if (do_mem) begin
            g = '{addr: maddr, wdata: wdata, sel: sel, we: we, cyc: cyc, unstable: 1'b0};
            exp_q.push_back(g);
            m_mem_rdata = (exp_err || we) ? 32'h0 : ref_read(maddr);
            if (we && !exp_err) ref_mem[maddr] = merge(ref_read(maddr), sel, wdata);
        end
        if (do_if) begin
            g = '{addr: iaddr, wdata: 32'h0, sel: 4'hF, we: 1'b0, cyc: cyc, unstable: 1'b0};
            exp_q.push_back(g);
            m_if_rdata = exp_err ? 32'h0 : ref_read(iaddr);
        end

        ack_delay       = delay;
        bus.mem_req_i   = do_mem;
        bus.mem_we_i    = we;
        bus.mem_sel_i   = sel;
        bus.mem_addr_i  = maddr;
        bus.mem_wdata_i = wdata;
        bus.if_req_i    = do_if;
        bus.if_addr_i   = iaddr;
        #1;
        check("stall_on_req", bus.stall_o, 1'b1);

        mem_pend = do_mem;
        if_pend  = do_if;
        n = 0;
        while ((mem_pend || if_pend) && n < 200) begin
            @(posedge clk); #1;
            n++;
            check("stall", bus.stall_o,
                  (mem_pend & ~bus.mem_ready_o) | (if_pend & ~bus.if_ready_o));
            if (!bus.mem_ready_o && !bus.if_ready_o) check("err_idle", bus.err_o, 1'b0);
            if (mem_pend && bus.mem_ready_o) begin
                got_mrd = bus.mem_rdata_o; got_merr = bus.err_o; mem_lat = n;
                mem_pend = 0; bus.mem_req_i = 1'b0;
            end else begin
                check("mem_ready_unexpected", bus.mem_ready_o, 1'b0);
            end
            if (if_pend && bus.if_ready_o) begin
                got_ird = bus.if_rdata_o; got_ierr = bus.err_o; if_lat = n;
                if_pend = 0; bus.if_req_i = 1'b0;
            end else begin
                check("if_ready_unexpected", bus.if_ready_o, 1'b0);
            end
        end
        check("ready_budget", mem_pend | if_pend, 1'b0);

        @(posedge clk); #1;
        check("mem_ready_pulse_width", bus.mem_ready_o, 1'b0);
        check("if_ready_pulse_width", bus.if_ready_o, 1'b0);
        check("err_after_ready", bus.err_o, 1'b0);
        check("stall_after", bus.stall_o, 1'b0);
        check("ram_req_after", bus.ram_req_o, 1'b0);
        if (do_mem) begin
            check("mem_rdata", got_mrd, m_mem_rdata);
            check("mem_err", got_merr, exp_err);
            check("mem_latency", mem_lat, cyc + 1);
        end
        if (do_if) begin
            check("if_rdata", got_ird, m_if_rdata);
            check("if_err", got_ierr, exp_err);
            check("if_latency", if_lat, do_mem ? 2 * cyc + 3 : cyc + 1);
        end
        check("mem_rdata_hold", bus.mem_rdata_o, m_mem_rdata);
        check("if_rdata_hold", bus.if_rdata_o, m_if_rdata);

        check("grant_count", grant_q.size(), exp_q.size());
        while (exp_q.size() > 0 && grant_q.size() > 0) begin
            g   = exp_q.pop_front();
            got = grant_q.pop_front();
            check("ram_addr", got.addr, g.addr);
            check("ram_we", got.we, g.we);
            check("ram_sel", got.sel, g.sel);
            if (g.we) check("ram_wdata", got.wdata, g.wdata);
            check("ram_req_cycles", got.cyc, g.cyc);
            check("ram_stable", got.unstable, 1'b0);
        end
        grant_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ram_req"}, bus.ram_req_o, 1'b0);
        check({tag, "_ram_we"}, bus.ram_we_o, 1'b0);
        check({tag, "_ram_sel"}, bus.ram_sel_o, 4'h0);
        check({tag, "_ram_addr"}, bus.ram_addr_o, 32'h0);
        check({tag, "_ram_wdata"}, bus.ram_wdata_o, 32'h0);
        check({tag, "_if_rdata"}, bus.if_rdata_o, 32'h0);
        check({tag, "_mem_rdata"}, bus.mem_rdata_o, 32'h0);
        check({tag, "_if_ready"}, bus.if_ready_o, 1'b0);
        check({tag, "_mem_ready"}, bus.mem_ready_o, 1'b0);
        check({tag, "_err"}, bus.err_o, 1'b0);
    endtask

    task automatic quiet_cycles(input string tag, input int cycles);
        repeat (cycles) begin
            @(posedge clk); #1;
            check({tag, "_mem_ready"}, bus.mem_ready_o, 1'b0);
            check({tag, "_if_ready"}, bus.if_ready_o, 1'b0);
            check({tag, "_ram_req"}, bus.ram_req_o, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    initial begin
        bit          r_mem, r_if, r_we;
        int          mode, dly;
        logic [3:0]  r_sel;
        logic [31:0] r_maddr, r_iaddr, r_wd;

        bus.if_req_i = 1'b0;  bus.if_addr_i = '0;
        bus.mem_req_i = 1'b0; bus.mem_we_i = 1'b0; bus.mem_sel_i = '0;
        bus.mem_addr_i = '0;  bus.mem_wdata_i = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        check("reset_stall", bus.stall_o, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single fetch with one-cycle ack
        ram_mem[32'h40] = 32'h2402_0005;
        ref_mem[32'h40] = 32'h2402_0005;
        run_pair(1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0000_0040, 1);

        // Simultaneous fetch and load: load served first
        run_pair(1'b1, 1'b1, 1'b0, 4'hF, 32'h0000_0100, 32'h1234_5678, 32'h0000_0104, 1);

        // Store byte, then fetch the merged word back
        run_pair(1'b1, 1'b0, 1'b1, 4'h2, 32'h0000_0200, 32'h0000_AB00, 32'h0, 2);
        run_pair(1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0000_0200, 1);

        // Five extra wait states
        run_pair(1'b1, 1'b0, 1'b0, 4'hF, 32'h0000_0104, 32'h0, 32'h0, 6);

        // Ack on the last permitted cycle still succeeds
        run_pair(1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0000_0108, WAIT_MAX);

        // Timeout, then a stray ack in IDLE is ignored
        run_pair(1'b1, 1'b0, 1'b0, 4'hF, 32'h0000_0108, 32'h0, 32'h0, 1000);
        stray_ack = 1'b1;
        quiet_cycles("stray_ack", 3);
        stray_ack = 1'b0;
        @(posedge clk); #1;

        // Fetch to establish a nonzero held value before the reset test
        run_pair(1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0000_0040, 1);

        // Reset during DATA_BUSY
        ack_delay       = 5;
        bus.mem_req_i   = 1'b1;
        bus.mem_we_i    = 1'b1;
        bus.mem_sel_i   = 4'hF;
        bus.mem_addr_i  = 32'h0000_0300;
        bus.mem_wdata_i = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        check("rst_pre_ram_req", bus.ram_req_o, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        bus.mem_req_i = 1'b0;
        @(posedge clk); #1;
        check_all_zero("rst_mid");
        rst = 1'b0;
        stray_ack = 1'b1;
        quiet_cycles("rst_pending_ack", 3);
        stray_ack = 1'b0;
        @(posedge clk); #1;
        grant_q.delete();
        m_if_rdata  = '0;
        m_mem_rdata = '0;
        run_pair(1'b1, 1'b0, 1'b0, 4'hF, 32'h0000_0300, 32'h0, 32'h0, 1);

        // Randomized mix of loads, stores, fetches, wait states and timeouts
        for (int it = 0; it < 40; it++) begin
            mode    = $urandom_range(0, 2);
            r_mem   = (mode != 1);
            r_if    = (mode != 0);
            r_we    = $urandom_range(0, 1);
            r_sel   = 4'($urandom_range(1, 15));
            r_maddr = 32'h0000_0400 + 32'($urandom_range(0, 7)) * 4;
            r_iaddr = 32'h0000_0400 + 32'($urandom_range(0, 7)) * 4;
            r_wd    = $urandom();
            dly     = $urandom_range(1, WAIT_MAX + 1);
            run_pair(r_mem, r_if, r_we, r_sel, r_maddr, r_wd, r_iaddr, dly);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
